// File: rtl/calc_pkg.sv
// Shared state and mode codes for the calculator controller and LED status display.
package calc_pkg;

  localparam int unsigned ST_W   = 4;
  localparam int unsigned MODE_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] ST_MENU    = 4'd1;
  localparam logic [ST_W-1:0] ST_INPUT   = 4'd2;
  localparam logic [ST_W-1:0] ST_GEN     = 4'd3;
  localparam logic [ST_W-1:0] ST_DISPLAY = 4'd4;
  localparam logic [ST_W-1:0] ST_COMPUTE = 4'd5;
  localparam logic [ST_W-1:0] ST_ERROR   = 4'd6;
  localparam logic [ST_W-1:0] ST_STORE   = 4'd7;
  localparam logic [ST_W-1:0] ST_SELECT  = 4'd8;
  localparam logic [ST_W-1:0] ST_WAIT    = 4'd9;

  localparam logic [MODE_W-1:0] MODE_INPUT   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_GEN     = 3'd1;
  localparam logic [MODE_W-1:0] MODE_DISPLAY = 3'd2;
  localparam logic [MODE_W-1:0] MODE_COMPUTE = 3'd3;

  // ERROR and WAIT both light the error indicator
  function automatic logic is_error_state(input logic [ST_W-1:0] st);
    return (st == ST_ERROR) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-cycle tick every CLK_HZ clocks; clr restarts the period from zero.
module sec_tick #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/calc_ctrl_fsm.sv
// Top-level menu/operation sequencer for the calculator datapath, with
// timed error recovery.
module calc_ctrl_fsm #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned WAIT_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_confirm,
  input  logic       btn_back,
  input  logic [2:0] mode,
  input  logic       input_done,
  input  logic       gen_done,
  input  logic       store_done,
  input  logic       display_done,
  input  logic       select_done,
  input  logic       compute_done,
  input  logic       op_error,
  output logic       input_start,
  output logic       gen_start,
  output logic       store_start,
  output logic       compute_start,
  output logic [3:0] state,
  output logic [3:0] countdown,
  output logic       error_flag
);

  import calc_pkg::*;

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_next;
  logic [3:0]      r_countdown;
  logic [3:0]      w_countdown;
  logic            r_input_start, r_gen_start, r_store_start, r_compute_start;
  logic            w_input_start, w_gen_start, w_store_start, w_compute_start;
  logic            r_error_flag;
  logic            w_error_flag;
  logic            w_wait_entry;
  logic            w_tick;

  // ERROR always advances to WAIT, so being in ERROR marks WAIT entry
  assign w_wait_entry = (r_state == ST_ERROR);

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_wait_entry),
    .tick (w_tick)
  );

  always_comb begin
    w_next          = r_state;
    w_countdown     = '0;
    w_input_start   = 1'b0;
    w_gen_start     = 1'b0;
    w_store_start   = 1'b0;
    w_compute_start = 1'b0;
    w_error_flag    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (btn_confirm) w_next = ST_MENU;
      end
      ST_MENU: begin
        if (btn_back) begin
          w_next = ST_IDLE;
        end else if (btn_confirm) begin
          case (mode)
            MODE_INPUT:   w_next = ST_INPUT;
            MODE_GEN:     w_next = ST_GEN;
            MODE_DISPLAY: w_next = ST_DISPLAY;
            MODE_COMPUTE: w_next = ST_SELECT;
            default:      w_next = ST_ERROR;
          endcase
        end
      end
      ST_INPUT: begin
        if (btn_back)        w_next = ST_MENU;
        else if (input_done) w_next = ST_STORE;
      end
      ST_GEN: begin
        if (gen_done) w_next = ST_STORE;
      end
      ST_STORE: begin
        if (store_done) w_next = ST_MENU;
      end
      ST_DISPLAY: begin
        if (btn_back || display_done) w_next = ST_MENU;
      end
      ST_SELECT: begin
        if (btn_back)         w_next = ST_MENU;
        else if (select_done) w_next = op_error ? ST_ERROR : ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (compute_done) w_next = ST_DISPLAY;
      end
      ST_ERROR: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (btn_back || (w_tick && (r_countdown <= 4'd1))) w_next = ST_MENU;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase

    // Strobes fire only on the edge that enters the state
    w_input_start   = (w_next == ST_INPUT)   && (r_state != ST_INPUT);
    w_gen_start     = (w_next == ST_GEN)     && (r_state != ST_GEN);
    w_store_start   = (w_next == ST_STORE)   && (r_state != ST_STORE);
    w_compute_start = (w_next == ST_COMPUTE) && (r_state != ST_COMPUTE);
    w_error_flag    = is_error_state(w_next);

    if (w_next == ST_WAIT) begin
      if (r_state != ST_WAIT) w_countdown = 4'(WAIT_SEC);
      else if (w_tick)        w_countdown = r_countdown - 4'd1;
      else                    w_countdown = r_countdown;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_countdown     <= '0;
      r_input_start   <= 1'b0;
      r_gen_start     <= 1'b0;
      r_store_start   <= 1'b0;
      r_compute_start <= 1'b0;
      r_error_flag    <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_countdown     <= w_countdown;
      r_input_start   <= w_input_start;
      r_gen_start     <= w_gen_start;
      r_store_start   <= w_store_start;
      r_compute_start <= w_compute_start;
      r_error_flag    <= w_error_flag;
    end
  end

  assign state         = r_state;
  assign countdown     = r_countdown;
  assign input_start   = r_input_start;
  assign gen_start     = r_gen_start;
  assign store_start   = r_store_start;
  assign compute_start = r_compute_start;
  assign error_flag    = r_error_flag;

endmodule

// File: tb/tb_calc_ctrl_fsm.sv
// Directed bench for calc_ctrl_fsm with a 10-cycle second and 3-second wait.
module tb_calc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_confirm = 1'b0;
  logic       btn_back = 1'b0;
  logic [2:0] mode = 3'd0;
  logic       input_done = 1'b0;
  logic       gen_done = 1'b0;
  logic       store_done = 1'b0;
  logic       display_done = 1'b0;
  logic       select_done = 1'b0;
  logic       compute_done = 1'b0;
  logic       op_error = 1'b0;
  logic       input_start, gen_start, store_start, compute_start;
  logic [3:0] state;
  logic [3:0] countdown;
  logic       error_flag;

  int n_checks = 0;
  int n_fail   = 0;

  calc_ctrl_fsm #(
    .CLK_HZ  (10),
    .WAIT_SEC(3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_confirm  (btn_confirm),
    .btn_back     (btn_back),
    .mode         (mode),
    .input_done   (input_done),
    .gen_done     (gen_done),
    .store_done   (store_done),
    .display_done (display_done),
    .select_done  (select_done),
    .compute_done (compute_done),
    .op_error     (op_error),
    .input_start  (input_start),
    .gen_start    (gen_start),
    .store_start  (store_start),
    .compute_start(compute_start),
    .state        (state),
    .countdown    (countdown),
    .error_flag   (error_flag)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int strobes();
    return int'({input_start, gen_start, store_start, compute_start});
  endfunction

  task automatic press_confirm();
    btn_confirm = 1'b1;
    step();
    btn_confirm = 1'b0;
  endtask

  task automatic press_back();
    btn_back = 1'b1;
    step();
    btn_back = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held
    step(2);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_strobes", strobes(), 0);
    check_eq("rst_countdown", int'(countdown), 0);
    check_eq("rst_error_flag", int'(error_flag), 0);
    rst = 1'b0;
    step();
    check_eq("idle_after_rst", int'(state), 0);

    // IDLE -> MENU -> INPUT
    press_confirm();
    check_eq("menu_entry", int'(state), 1);
    mode = 3'd0;
    press_confirm();
    check_eq("input_entry", int'(state), 2);
    check_eq("input_start_hi", strobes(), 4'b1000);
    step();
    check_eq("input_start_lo", strobes(), 0);
    check_eq("input_hold", int'(state), 2);

    // INPUT -> STORE -> MENU
    input_done = 1'b1; step(); input_done = 1'b0;
    check_eq("store_entry", int'(state), 7);
    check_eq("store_start_hi", strobes(), 4'b0010);
    step();
    check_eq("store_start_lo", strobes(), 0);
    store_done = 1'b1; step(); store_done = 1'b0;
    check_eq("store_to_menu", int'(state), 1);

    // Unconsumed done pulse ignored in MENU
    gen_done = 1'b1; step(); gen_done = 1'b0;
    check_eq("menu_ignores_done", int'(state), 1);

    // SELECT with operand error -> ERROR -> WAIT countdown -> MENU
    mode = 3'd3;
    press_confirm();
    check_eq("select_entry", int'(state), 8);
    op_error = 1'b1; select_done = 1'b1; step(); select_done = 1'b0; op_error = 1'b0;
    check_eq("error_entry", int'(state), 6);
    check_eq("error_flag_err", int'(error_flag), 1);
    step();
    check_eq("wait_entry", int'(state), 9);
    check_eq("wait_cd3_first", int'(countdown), 3);
    step(4);
    press_confirm();
    check_eq("wait_ignores_confirm", int'(state), 9);
    step(4);
    check_eq("wait_cd3_last", int'(countdown), 3);
    step();
    check_eq("wait_cd2_first", int'(countdown), 2);
    step(9);
    check_eq("wait_cd2_last", int'(countdown), 2);
    step();
    check_eq("wait_cd1_first", int'(countdown), 1);
    step(9);
    check_eq("wait_cd1_last", int'(countdown), 1);
    check_eq("wait_still", int'(state), 9);
    check_eq("wait_error_flag", int'(error_flag), 1);
    step();
    check_eq("wait_expire_state", int'(state), 1);
    check_eq("wait_expire_cd", int'(countdown), 0);
    check_eq("wait_expire_flag", int'(error_flag), 0);

    // Invalid mode -> ERROR -> WAIT, back aborts the wait
    mode = 3'd5;
    press_confirm();
    check_eq("bad_mode_error", int'(state), 6);
    step();
    check_eq("bad_mode_wait", int'(state), 9);
    check_eq("bad_mode_cd", int'(countdown), 3);
    press_back();
    check_eq("wait_back_state", int'(state), 1);
    check_eq("wait_back_cd", int'(countdown), 0);
    check_eq("wait_back_flag", int'(error_flag), 0);

    // GEN is non-abortable
    mode = 3'd1;
    press_confirm();
    check_eq("gen_entry", int'(state), 3);
    check_eq("gen_start_hi", strobes(), 4'b0100);
    press_back();
    check_eq("gen_ignores_back", int'(state), 3);
    check_eq("gen_start_lo", strobes(), 0);
    gen_done = 1'b1; step(); gen_done = 1'b0;
    check_eq("gen_to_store", int'(state), 7);
    check_eq("gen_store_start", strobes(), 4'b0010);
    store_done = 1'b1; step(); store_done = 1'b0;
    check_eq("gen_store_menu", int'(state), 1);

    // SELECT ok -> COMPUTE; done beats back there
    mode = 3'd3;
    press_confirm();
    select_done = 1'b1; step(); select_done = 1'b0;
    check_eq("compute_entry", int'(state), 5);
    check_eq("compute_start_hi", strobes(), 4'b0001);
    btn_back = 1'b1; compute_done = 1'b1; step(); btn_back = 1'b0; compute_done = 1'b0;
    check_eq("compute_done_wins", int'(state), 4);
    check_eq("compute_start_lo", strobes(), 0);
    press_back();
    check_eq("display_back", int'(state), 1);

    // DISPLAY via menu, exits on display_done
    mode = 3'd2;
    press_confirm();
    check_eq("display_entry", int'(state), 4);
    display_done = 1'b1; step(); display_done = 1'b0;
    check_eq("display_done_menu", int'(state), 1);

    // INPUT re-entry strobe, then back wins over coincident done
    mode = 3'd0;
    press_confirm();
    check_eq("input_reentry_strobe", strobes(), 4'b1000);
    btn_back = 1'b1; input_done = 1'b1; step(); btn_back = 1'b0; input_done = 1'b0;
    check_eq("input_back_wins", int'(state), 1);
    check_eq("input_back_no_store", strobes(), 0);
    press_back();
    check_eq("menu_back_idle", int'(state), 0);

    // Async reset mid-WAIT at countdown 2
    press_confirm();
    mode = 3'd5;
    press_confirm();
    step();
    check_eq("pre_rst_wait", int'(state), 9);
    step(10);
    check_eq("pre_rst_cd2", int'(countdown), 2);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_state", int'(state), 0);
    check_eq("async_rst_cd", int'(countdown), 0);
    check_eq("async_rst_flag", int'(error_flag), 0);
    step(2);
    rst = 1'b0;
    step();
    check_eq("post_rst_state", int'(state), 0);
    check_eq("post_rst_strobes", strobes(), 0);
    step();
    check_eq("post_rst_idle_hold", int'(state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
